// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-style data port onto an AXI4-Lite master, stalling the pipeline per request.
// Optional macro SRAM_BRIDGE_KSEG_MAP_EN folds kseg0/kseg1 addresses down to physical space.
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sram_en,
  input  logic [DATA_W/8-1:0] sram_wen,
  input  logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W-1:0]   sram_rdata,
  output logic                stallreq,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                aw_fire, w_fire;

  // Responses are not reported back to the core.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
`ifdef SRAM_BRIDGE_KSEG_MAP_EN
    if (a[ADDR_W-1 -: 2] == 2'b10) return {3'b000, a[ADDR_W-4:0]};
    return a;
`else
    return a;
`endif
  endfunction

  assign arvalid    = (state_q == S_AR);
  assign rready     = (state_q == S_R);
  assign bready     = (state_q == S_B);
  assign awvalid    = (state_q == S_AWW) && !aw_done_q;
  assign wvalid     = (state_q == S_AWW) && !w_done_q;
  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign sram_rdata = rdata_q;

  // Combinational so the stall is visible in the same cycle the request appears.
  assign stallreq = ((state_q == S_IDLE) && sram_en) || (state_q == S_AR) ||
                    (state_q == S_R) || (state_q == S_AWW) || (state_q == S_B);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (sram_en) begin
          addr_d    = map_addr(sram_addr);
          wdata_d   = sram_wdata;
          wstrb_d   = sram_wen;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (sram_wen == '0) ? S_AR : S_AWW;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = S_DONE;
        end
      end
      S_AWW: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: if (bvalid) state_d = S_DONE;
      // The request still on the port here is the one just serviced.
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: reads, writes, back-to-back, async reset, idle, address mapping.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;
  int ar_hs = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int ar0, aw0, w0;

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .stallreq(stallreq),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready)   w_hs  <= w_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_valids", 64'({stallreq, arvalid, rready, awvalid, wvalid, bready}), 64'h0);
    check("rst_addr", 64'({araddr, awaddr}), 64'h0);
    check("rst_wdata_wstrb", 64'({wdata, wstrb}), 64'h0);
    check("rst_rdata", 64'(sram_rdata), 64'h0);
    @(negedge clk); rst = 1'b0;

    // Minimum-latency read
    ar0 = ar_hs;
    @(negedge clk); sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h0000_1000; arready = 1'b1; #1;
    check("rd_T_stall", 64'(stallreq), 64'h1);
    check("rd_T_arvalid", 64'(arvalid), 64'h0);
    @(negedge clk); #1;
    check("rd_T1_arvalid", 64'(arvalid), 64'h1);
    check("rd_T1_araddr", 64'(araddr), 64'h1000);
    check("rd_T1_stall", 64'(stallreq), 64'h1);
    @(negedge clk); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    check("rd_T2_rready", 64'(rready), 64'h1);
    check("rd_T2_stall", 64'(stallreq), 64'h1);
    @(negedge clk); rvalid = 1'b0; rdata = 32'h0; #1;
    check("rd_T3_stall", 64'(stallreq), 64'h0);
    check("rd_T3_rdata", 64'(sram_rdata), 64'hDEAD_BEEF);
    check("rd_ar_count", 64'(ar_hs - ar0), 64'h1);
    @(negedge clk); sram_en = 1'b0; arready = 1'b0; #1;
    check("rd_after_stall", 64'(stallreq), 64'h0);

    // Write with W before AW and delayed B
    @(negedge clk); sram_en = 1'b1; sram_wen = 4'b0011; sram_addr = 32'h0000_2000;
    sram_wdata = 32'h1234_5678; #1;
    check("wr_T_stall", 64'(stallreq), 64'h1);
    @(negedge clk); wready = 1'b1; #1;
    check("wr_T1_valids", 64'({awvalid, wvalid}), 64'h3);
    check("wr_T1_wstrb", 64'(wstrb), 64'h3);
    check("wr_T1_awaddr", 64'(awaddr), 64'h2000);
    check("wr_T1_wdata", 64'(wdata), 64'h1234_5678);
    @(negedge clk); wready = 1'b0; #1;
    check("wr_T2_valids", 64'({awvalid, wvalid}), 64'h2);
    @(negedge clk); awready = 1'b1; #1;
    check("wr_T3_valids", 64'({awvalid, wvalid}), 64'h2);
    @(negedge clk); awready = 1'b0; #1;
    check("wr_T4_state", 64'({awvalid, wvalid, bready, stallreq}), 64'h3);
    @(negedge clk); bvalid = 1'b1; #1;
    check("wr_T5_bready", 64'({bready, stallreq}), 64'h3);
    @(negedge clk); bvalid = 1'b0; #1;
    check("wr_T6_stall", 64'({bready, stallreq}), 64'h0);
    check("wr_rdata_kept", 64'(sram_rdata), 64'hDEAD_BEEF);
    @(negedge clk); sram_en = 1'b0; sram_wen = 4'h0;

    // Back-to-back read then write, all handshakes tied high
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    @(negedge clk); arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    rdata = 32'hCAFE_F00D; sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h0000_3000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    check("b2b_rd_done", 64'({stallreq, sram_rdata}), 64'h0_CAFE_F00D);
    @(negedge clk); sram_wen = 4'hF; sram_addr = 32'h0000_3004; sram_wdata = 32'hA5A5_A5A5; #1;
    check("b2b_wr_accept", 64'({stallreq, awvalid}), 64'h2);
    @(negedge clk); #1;
    check("b2b_wr_aww", 64'({awvalid, wvalid}), 64'h3);
    @(negedge clk); #1;
    check("b2b_wr_b", 64'({bready, stallreq}), 64'h3);
    @(negedge clk); #1;
    check("b2b_wr_done", 64'({stallreq, sram_rdata}), 64'h0_CAFE_F00D);
    @(negedge clk); sram_en = 1'b0; sram_wen = 4'h0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; #1;
    check("b2b_hs_counts", 64'({8'(ar_hs - ar0), 8'(aw_hs - aw0), 8'(w_hs - w0)}), 64'h01_0101);

    // Address mapping (kseg1 then kseg0)
    @(negedge clk); sram_en = 1'b1; sram_addr = 32'hBFC0_0000; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h0000_0011;
    @(negedge clk); #1;
`ifdef SRAM_BRIDGE_KSEG_MAP_EN
    check("map_kseg1", 64'(araddr), 64'h1FC0_0000);
`else
    check("map_kseg1", 64'(araddr), 64'hBFC0_0000);
`endif
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); sram_addr = 32'h8000_0010;
    @(negedge clk); #1;
`ifdef SRAM_BRIDGE_KSEG_MAP_EN
    check("map_kseg0", 64'(araddr), 64'h0000_0010);
`else
    check("map_kseg0", 64'(araddr), 64'h8000_0010);
`endif
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0;

    // Asynchronous reset while waiting in R
    @(negedge clk); sram_en = 1'b1; sram_addr = 32'h0000_4000; arready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("arst_pre_rready", 64'(rready), 64'h1);
    sram_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valids", 64'({rready, stallreq, arvalid}), 64'h0);
    check("arst_rdata", 64'(sram_rdata), 64'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("arst_release_stall", 64'(stallreq), 64'h0);
    @(negedge clk); sram_en = 1'b1; sram_addr = 32'h0000_5000; rvalid = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    check("arst_idle_then_ar", 64'({arvalid, araddr}), 64'h1_0000_5000);
    @(negedge clk);
    @(negedge clk); #1;
    check("arst_read_done", 64'({stallreq, sram_rdata}), 64'h0_5555_AAAA);
    @(negedge clk); sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;

    // Idle with no request
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("idle_quiet", 64'({stallreq, arvalid, rready, awvalid, wvalid, bready}), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
